// File: rtl/barrel_shifter_32_if.sv
// -----------------------------------------------------------------------------
// barrel_shifter_32_if
// Operand/result bundle for the barrel_shifter_32 operand-2 shifter.
//
// Signals:
//   in_valid         operands valid this cycle (master -> slave)
//   Shift_Data[31:0] operand to shift
//   Shift_Num[7:0]   shift amount (immediate mode uses [4:0] only)
//   Carry_flag       current CPSR C flag
//   SHIFT_OP[2:0]    [2:1] 00 LSL, 01 LSR, 10 ASR, 11 ROR; [0] 0 imm, 1 reg
//   Shift_out[31:0]  registered shifted result (slave -> master)
//   Shift_carry_out  registered shifter carry-out
//   out_valid        high one cycle after an accepted in_valid
//   Shift_zero       registered "result is zero" flag, present only when
//                    BARREL_SHIFT_ZERO_FLAG_EN is defined
//
// Modports: master drives operands, slave (the shifter) drives results.
// -----------------------------------------------------------------------------
interface barrel_shifter_32_if;
    logic        in_valid;
    logic [31:0] Shift_Data;
    logic [7:0]  Shift_Num;
    logic        Carry_flag;
    logic [2:0]  SHIFT_OP;
    logic [31:0] Shift_out;
    logic        Shift_carry_out;
    logic        out_valid;
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
    logic        Shift_zero;
`endif

    modport master (
        output in_valid,
        output Shift_Data,
        output Shift_Num,
        output Carry_flag,
        output SHIFT_OP,
        input  Shift_out,
        input  Shift_carry_out,
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
        input  Shift_zero,
`endif
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  Shift_Data,
        input  Shift_Num,
        input  Carry_flag,
        input  SHIFT_OP,
        output Shift_out,
        output Shift_carry_out,
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
        output Shift_zero,
`endif
        output out_valid
    );
endinterface

// File: rtl/barrel_shifter_32.sv
// -----------------------------------------------------------------------------
// barrel_shifter_32
// ARM-style 32-bit operand-2 barrel shifter. Supports LSL/LSR/ASR/ROR/RRX with
// immediate-style (5-bit) or register-style (8-bit) shift amounts and produces
// the shifted operand plus the shifter carry-out for the C flag. The shift core
// is a combinational 16/8/4/2/1 log shifter; result and carry are registered
// (one-cycle latency, one result per cycle, no stall).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (overrides bus.in_valid)
//   bus   barrel_shifter_32_if.slave: operands in, registered results out
//
// Optional feature: define BARREL_SHIFT_ZERO_FLAG_EN to add bus.Shift_zero,
// a registered flag that is 1 when the captured Shift_out equals zero.
// -----------------------------------------------------------------------------
module barrel_shifter_32 (
    input logic              clk,
    input logic              rst,
    barrel_shifter_32_if.slave bus
);

    typedef enum logic [1:0] {
        ShLsl = 2'b00,
        ShLsr = 2'b01,
        ShAsr = 2'b10,
        ShRor = 2'b11
    } shift_type_e;

    // -------------------------------------------------------------------------
    // Operand decode
    // -------------------------------------------------------------------------
    shift_type_e shift_type;
    logic        reg_mode;
    logic [7:0]  amount;
    logic [4:0]  amount_lo;
    logic        amount_zero;
    logic        amount_ge32;
    logic        amount_eq32;
    logic [31:0] data;

    assign shift_type  = shift_type_e'(bus.SHIFT_OP[2:1]);
    assign reg_mode    = bus.SHIFT_OP[0];
    assign data        = bus.Shift_Data;
    // Immediate mode only ever sees the low five bits of the amount.
    assign amount      = reg_mode ? bus.Shift_Num : {3'b000, bus.Shift_Num[4:0]};
    assign amount_lo   = amount[4:0];
    assign amount_zero = (amount == 8'd0);
    assign amount_ge32 = |amount[7:5];
    assign amount_eq32 = (amount == 8'd32);

    // -------------------------------------------------------------------------
    // Log shifter core: five conditional stages of 16/8/4/2/1, shift type
    // selected per stage. Amounts of 0 and >= 32 are handled by the decode
    // below, so the core only needs to be correct for 1..31.
    // -------------------------------------------------------------------------
    function automatic logic [31:0] shift_stage(input logic [31:0]  x,
                                                input shift_type_e  t,
                                                input logic         fill,
                                                input int unsigned  sh);
        logic [31:0] r;
        unique case (t)
            ShLsl:        r = x << sh;
            ShLsr, ShAsr: r = (x >> sh) | (fill ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            ShRor:        r = (x >> sh) | (x << (32 - sh));
            default:      r = x;
        endcase
        return r;
    endfunction

    logic        sign_fill;
    logic [31:0] stage16;
    logic [31:0] stage8;
    logic [31:0] stage4;
    logic [31:0] stage2;
    logic [31:0] core_out;

    assign sign_fill = (shift_type == ShAsr) && data[31];

    assign stage16  = amount_lo[4] ? shift_stage(data,    shift_type, sign_fill, 16) : data;
    assign stage8   = amount_lo[3] ? shift_stage(stage16, shift_type, sign_fill, 8)  : stage16;
    assign stage4   = amount_lo[2] ? shift_stage(stage8,  shift_type, sign_fill, 4)  : stage8;
    assign stage2   = amount_lo[1] ? shift_stage(stage4,  shift_type, sign_fill, 2)  : stage4;
    assign core_out = amount_lo[0] ? shift_stage(stage2,  shift_type, sign_fill, 1)  : stage2;

    // Carry is the last bit shifted out: d[32-n] for left, d[n-1] for right
    // and rotate. Both indices wrap mod 32, matching the 5-bit amount.
    logic [4:0] carry_idx_left;
    logic [4:0] carry_idx_right;
    logic       core_carry;

    assign carry_idx_left  = 5'd0 - amount_lo;
    assign carry_idx_right = amount_lo - 5'd1;
    assign core_carry      = (shift_type == ShLsl) ? data[carry_idx_left]
                                                   : data[carry_idx_right];

    // -------------------------------------------------------------------------
    // Special-case selection (zero amount encodings, amounts >= 32)
    // -------------------------------------------------------------------------
    logic [31:0] result_d;
    logic        carry_d;

    always_comb begin
        result_d = core_out;
        carry_d  = core_carry;

        if (amount_zero) begin
            if (reg_mode) begin
                // Register shift by zero leaves operand and C untouched.
                result_d = data;
                carry_d  = bus.Carry_flag;
            end else begin
                unique case (shift_type)
                    ShLsl: begin
                        result_d = data;
                        carry_d  = bus.Carry_flag;
                    end
                    ShLsr: begin
                        // #0 encodes #32
                        result_d = 32'h0;
                        carry_d  = data[31];
                    end
                    ShAsr: begin
                        // #0 encodes #32
                        result_d = {32{data[31]}};
                        carry_d  = data[31];
                    end
                    ShRor: begin
                        // #0 encodes RRX: rotate right by one through C
                        result_d = {bus.Carry_flag, data[31:1]};
                        carry_d  = data[0];
                    end
                    default: begin
                        result_d = data;
                        carry_d  = bus.Carry_flag;
                    end
                endcase
            end
        end else if (amount_ge32) begin
            // Only reachable in register mode.
            unique case (shift_type)
                ShLsl: begin
                    result_d = 32'h0;
                    carry_d  = amount_eq32 ? data[0] : 1'b0;
                end
                ShLsr: begin
                    result_d = 32'h0;
                    carry_d  = amount_eq32 ? data[31] : 1'b0;
                end
                ShAsr: begin
                    result_d = {32{data[31]}};
                    carry_d  = data[31];
                end
                ShRor: begin
                    // Rotation is mod 32; a multiple of 32 leaves the operand
                    // intact but still reports bit 31 as carry.
                    if (amount_lo == 5'd0) begin
                        result_d = data;
                        carry_d  = data[31];
                    end
                end
                default: begin
                    result_d = data;
                    carry_d  = bus.Carry_flag;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic [31:0] shift_out_q;
    logic        carry_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_out_q <= 32'h0;
            carry_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                shift_out_q <= result_d;
                carry_q     <= carry_d;
            end
        end
    end

    assign bus.Shift_out       = shift_out_q;
    assign bus.Shift_carry_out = carry_q;
    assign bus.out_valid       = valid_q;

`ifdef BARREL_SHIFT_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (bus.in_valid) begin
            zero_q <= (result_d == 32'h0);
        end
    end

    assign bus.Shift_zero = zero_q;
`endif

endmodule

// File: tb/tb_barrel_shifter_32.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_32
// Self-checking bench for barrel_shifter_32. Expected results are pushed to a
// scoreboard queue when operands are driven and popped when out_valid is seen.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_32;

    logic clk;
    logic rst;

    barrel_shifter_32_if bus ();

    barrel_shifter_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic        carry;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model written directly from the architectural definition
    // using wide shifts rather than a staged shifter.
    task automatic ref_model(input logic [2:0] op, input logic [7:0] num, input logic [31:0] d,
                             input logic cf, output logic [31:0] o, output logic c);
        int          n;
        logic [63:0] w;
        n = op[0] ? int'(num) : int'(num[4:0]);
        o = d;
        c = cf;
        case (op[2:1])
            2'b00: begin
                if (n == 0) begin
                    o = d; c = cf;
                end else if (n <= 32) begin
                    w = {32'h0, d} << n;
                    o = w[31:0]; c = w[32];
                end else begin
                    o = 32'h0; c = 1'b0;
                end
            end
            2'b01: begin
                if (n == 0 && op[0]) begin
                    o = d; c = cf;
                end else begin
                    if (n == 0) n = 32;
                    if (n <= 32) begin
                        w = {d, 32'h0} >> n;
                        o = w[63:32]; c = w[31];
                    end else begin
                        o = 32'h0; c = 1'b0;
                    end
                end
            end
            2'b10: begin
                if (n == 0 && op[0]) begin
                    o = d; c = cf;
                end else begin
                    if (n == 0 || n > 32) n = 32;
                    w = $signed({d, 32'h0}) >>> n;
                    o = w[63:32]; c = w[31];
                end
            end
            default: begin
                if (n == 0 && !op[0]) begin
                    o = {cf, d[31:1]}; c = d[0];
                end else if (n == 0) begin
                    o = d; c = cf;
                end else begin
                    w = {d, d} >> (n % 32);
                    o = w[31:0]; c = o[31];
                end
            end
        endcase
    endtask

    // Drive one valid operation and record its expected result.
    task automatic send(input string tag, input logic [2:0] op, input logic [7:0] num,
                        input logic [31:0] d, input logic cf,
                        input logic [31:0] eo, input logic ec);
        exp_t e;
        bus.in_valid   = 1'b1;
        bus.SHIFT_OP   = op;
        bus.Shift_Num  = num;
        bus.Shift_Data = d;
        bus.Carry_flag = cf;
        if (!rst) begin
            e.tag = tag; e.out = eo; e.carry = ec;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_model(input string tag, input logic [2:0] op, input logic [7:0] num,
                              input logic [31:0] d, input logic cf);
        logic [31:0] o;
        logic        c;
        ref_model(op, num, d, cf, o, c);
        send(tag, op, num, d, cf, o, c);
    endtask

    task automatic idle(input int cycles);
        bus.in_valid   = 1'b0;
        bus.Shift_Data = 32'hDEAD_BEEF;
        bus.Shift_Num  = 8'hA5;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: out_valid timing, scoreboard compare, hold behaviour
    // -------------------------------------------------------------------------
    logic        started = 1'b0;
    logic        edge_rst = 1'b0;
    logic        edge_valid = 1'b0;
    logic [31:0] hold_out = 32'h0;
    logic        hold_carry = 1'b0;

    always @(posedge clk) begin
        started    <= 1'b1;
        edge_rst   <= rst;
        edge_valid <= bus.in_valid && !rst;
    end

    always @(negedge clk) begin
        if (started) begin
            check_val("out_valid", {63'h0, bus.out_valid}, {63'h0, edge_valid});
            if (edge_rst) begin
                check_val("rst_out", {32'h0, bus.Shift_out}, 64'h0);
                check_val("rst_carry", {63'h0, bus.Shift_carry_out}, 64'h0);
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
                check_val("rst_zero", {63'h0, bus.Shift_zero}, 64'h0);
`endif
                hold_out   <= 32'h0;
                hold_carry <= 1'b0;
            end else if (edge_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_val({e.tag, "_out"}, {32'h0, bus.Shift_out}, {32'h0, e.out});
                    check_val({e.tag, "_carry"}, {63'h0, bus.Shift_carry_out}, {63'h0, e.carry});
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
                    check_val({e.tag, "_zero"}, {63'h0, bus.Shift_zero},
                              {63'h0, (e.out == 32'h0)});
`endif
                    hold_out   <= e.out;
                    hold_carry <= e.carry;
                end
            end else begin
                check_val("hold_out", {32'h0, bus.Shift_out}, {32'h0, hold_out});
                check_val("hold_carry", {63'h0, bus.Shift_carry_out}, {63'h0, hold_carry});
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
                check_val("hold_zero", {63'h0, bus.Shift_zero}, {63'h0, (hold_out == 32'h0)});
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        logic [7:0] nums[6];
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.Shift_Data = 32'hFFFF_FFFF;
        bus.Shift_Num  = 8'd1;
        bus.SHIFT_OP   = 3'b000;
        bus.Carry_flag = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        send("lsl_imm1",  3'b000, 8'd1,  32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        send("lsr_imm0",  3'b010, 8'd0,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        send("rrx",       3'b110, 8'd0,  32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1);
        send("asr_reg40", 3'b101, 8'd40, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send("lsr_reg33", 3'b011, 8'd33, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
        send("ror_reg36", 3'b111, 8'd36, 32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1);
        send("lsr_reg0",  3'b011, 8'd0,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);
        idle(3);

        // Back-to-back immediate LSR
        send("b2b_1", 3'b010, 8'd1, 32'hF000_0000, 1'b1, 32'h7800_0000, 1'b0);
        send("b2b_2", 3'b010, 8'd2, 32'hF000_0000, 1'b1, 32'h3C00_0000, 1'b0);
        send("b2b_3", 3'b010, 8'd3, 32'hF000_0000, 1'b1, 32'h1E00_0000, 1'b0);
        send("b2b_4", 3'b010, 8'd4, 32'hF000_0000, 1'b1, 32'h0F00_0000, 1'b0);

        // Register boundary amounts
        send("lsl_reg32", 3'b001, 8'd32, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        send("lsr_reg32", 3'b011, 8'd32, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        send("ror_reg64", 3'b111, 8'd64, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1);
        send("asr_imm0",  3'b100, 8'd0,  32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        send("lsl_imm31", 3'b000, 8'd31, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1);
        send("imm_hibits", 3'b000, 8'hE1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        idle(1);

        // Reset arriving with a valid operand discards it
        rst = 1'b1;
        send("rst_drop", 3'b000, 8'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        idle(2);

        // Randomised coverage against the reference model
        nums[0] = 8'd0;  nums[1] = 8'd1;  nums[2] = 8'd31;
        nums[3] = 8'd32; nums[4] = 8'd33; nums[5] = 8'd255;
        for (int i = 0; i < 120; i++) begin
            logic [7:0] num;
            num = ($urandom_range(0, 1) == 0) ? nums[$urandom_range(0, 5)]
                                              : 8'($urandom_range(0, 255));
            send_model("rand", 3'($urandom_range(0, 7)), num, $urandom(),
                       1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(3);

        check_val("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
